// File: rtl/state_sequencer_pkg.sv
// Shared definitions for the instruction-cycle sequencer: state encoding and
// default retired-counter width.
package state_sequencer_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_HALTED  = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_OPERAND = 3'd3,
    ST_EXEC    = 3'd4,
    ST_WRITE   = 3'd5
  } state_t;

  // Post-reset state: running machines come up fetching, others wait for start.
  function automatic state_t reset_state(input bit run);
    return run ? ST_FETCH : ST_HALTED;
  endfunction

endpackage

// File: rtl/state_sequencer_phase_divider.sv
// Divide-by-two phase generator. cdiv toggles on every edge while the machine
// runs and is parked low while halted; the advance strobe marks edges where
// cdiv is high before the edge, i.e. the second half of each machine state.
module phase_divider (
  input  logic i_clk,
  input  logic i_nreset,
  input  logic i_halted,
  output logic o_cdiv,
  output logic o_ncdiv,
  output logic o_adv
);

  logic r_cdiv;

  // Toggle while running; clear on the halting edge and hold low in HALTED.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_cdiv <= 1'b0;
    end else if (i_halted) begin
      r_cdiv <= 1'b0;
    end else begin
      r_cdiv <= ~r_cdiv;
    end
  end

  assign o_cdiv  = r_cdiv;
  assign o_ncdiv = ~r_cdiv;
  assign o_adv   = r_cdiv & ~i_halted;

endmodule

// File: rtl/state_sequencer.sv
// Instruction-cycle sequencer with divided clock phase and retired counter.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   HALTED  | stopped, cdiv parked low, stop request asserted
//   FETCH   | fetching opcode word, stretched by mem_wait
//   DECODE  | decoding, chooses operand fetch or direct execute
//   OPERAND | fetching operand word, stretched by mem_wait
//   EXEC    | executing; a halt instruction retires and stops here
//   WRITE   | write-back; retires the instruction on exit
module state_sequencer #(
  parameter int CNT_W     = state_sequencer_pkg::CNT_W_DEFAULT,
  parameter bit RESET_RUN = 1'b1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start,
  input  logic             halt,
  input  logic             mem_wait,
  input  logic             two_word,
  output logic             cdiv,
  output logic             ncdiv,
  output logic             st_fetch,
  output logic             st_decode,
  output logic             st_operand,
  output logic             st_exec,
  output logic             st_write,
  output logic             nstop_req,
  output logic [CNT_W-1:0] retired
);

  import state_sequencer_pkg::*;

  localparam state_t ST_RESET = reset_state(RESET_RUN);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_halted;
  logic             w_adv;
  logic             w_retire;
  logic [CNT_W-1:0] r_retired;

  assign w_halted = (r_state == ST_HALTED);

  phase_divider u_phase_divider (
    .i_clk    (clk),
    .i_nreset (nreset),
    .i_halted (w_halted),
    .o_cdiv   (cdiv),
    .o_ncdiv  (ncdiv),
    .o_adv    (w_adv)
  );

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and retire strobe; leaving HALTED is not phase-gated.
  always_comb begin
    w_state_nxt = r_state;
    w_retire    = 1'b0;
    case (r_state)
      ST_HALTED: begin
        if (start) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (w_adv && !mem_wait) w_state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        if (w_adv) w_state_nxt = two_word ? ST_OPERAND : ST_EXEC;
      end
      ST_OPERAND: begin
        if (w_adv && !mem_wait) w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        if (w_adv) begin
          if (halt) begin
            w_state_nxt = ST_HALTED;
            w_retire    = 1'b1;
          end else begin
            w_state_nxt = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (w_adv) begin
          w_state_nxt = ST_FETCH;
          w_retire    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_RESET;
      end
    endcase
  end

  // Retired-instruction counter, wraps naturally at all-ones.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign retired    = r_retired;
  assign st_fetch   = (r_state == ST_FETCH);
  assign st_decode  = (r_state == ST_DECODE);
  assign st_operand = (r_state == ST_OPERAND);
  assign st_exec    = (r_state == ST_EXEC);
  assign st_write   = (r_state == ST_WRITE);
  assign nstop_req  = ~w_halted;

endmodule

// File: doc/state_sequencer.md
STATE_SEQUENCER -- requirements
Module: state_sequencer

Interface
REQ-001 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 Parameter RESET_RUN, default 1, selects the post-reset state: 1 = FETCH, 0 = HALTED.
REQ-003 Port clk  input  1  system clock; all state changes on rising edge.
REQ-004 Port nreset  input  1  reset, asynchronous, active-low.
REQ-005 Port start  input  1  run request; sampled only in HALTED.
REQ-006 Port halt  input  1  halt instruction decoded; sampled in EXEC.
REQ-007 Port mem_wait  input  1  memory not ready; stretches FETCH and OPERAND.
REQ-008 Port two_word  input  1  current instruction carries an operand word; sampled in DECODE.
REQ-009 Port cdiv  output  1  divided clock phase, toggles each running clk edge.
REQ-010 Port ncdiv  output  1  always the complement of cdiv.
REQ-011 Port st_fetch, st_decode, st_operand, st_exec, st_write  output  1 each  one-hot machine state.
REQ-012 Port nstop_req  output  1  active-low stop request to the clock generator, low while HALTED.
REQ-013 Port retired  output  CNT_W  count of completed instructions.

Function
REQ-014 States: HALTED, FETCH, DECODE, OPERAND, EXEC, WRITE, 3-bit encoded internally; the st_* outputs are decoded from it, and all are 0 in HALTED.
REQ-015 Outside HALTED, cdiv toggles on every clk edge; in HALTED, cdiv holds 0.
REQ-016 State advances only on an edge where cdiv is 1 before the edge ("advance edge"), so each machine state lasts 2 clk cycles minimum.
REQ-017 FETCH -> DECODE on an advance edge with mem_wait=0; with mem_wait=1, it stays in FETCH and cdiv keeps toggling.
REQ-018 DECODE -> OPERAND if two_word=1, else -> EXEC.
REQ-019 OPERAND -> EXEC on an advance edge with mem_wait=0; otherwise it holds, per REQ-017.
REQ-020 EXEC -> HALTED if halt=1, else -> WRITE.
REQ-021 WRITE -> FETCH; retired increments by 1 on that transition and wraps from all-ones to 0.
REQ-022 An EXEC -> HALTED transition also increments retired, because the halt instruction counts as retired.
REQ-023 HALTED -> FETCH on the first clk edge with start=1; this transition is not gated by cdiv, and cdiv is 0 entering FETCH.
REQ-024 When start and halt are both 1 in EXEC, halt wins; start is ignored outside HALTED.
REQ-025 nstop_req = 0 exactly while in HALTED; otherwise 1.
REQ-026 No combinational path from inputs to outputs; all outputs are registered or decoded from registered state.

Reset
REQ-027 nreset low forces, asynchronously: state = FETCH if RESET_RUN=1 else HALTED; cdiv=0, ncdiv=1; retired=0.
REQ-028 nreset asserted mid-instruction, including during a mem_wait stretch, abandons the instruction with no retired increment.
REQ-029 Deassertion is taken synchronously on the next clk edge; the first toggle of cdiv occurs on that edge when running.

Structure
REQ-030 A shared package holds the state encoding constants (HALTED=0, FETCH=1, DECODE=2, OPERAND=3, EXEC=4, WRITE=5) and the CNT_W default.
REQ-031 One sub-module, phase_divider, owns cdiv/ncdiv generation and the advance-edge strobe; the sequencer FSM and counter sit in state_sequencer.

Verification
REQ-032 Reset with RESET_RUN=1 and all inputs 0 -> FETCH for 2 clks, DECODE 2, EXEC 2, WRITE 2, FETCH; retired=1 after 8 clks.
REQ-033 two_word=1 in DECODE plus mem_wait=1 for 3 clks in OPERAND -> OPERAND lasts 4 clks (2 + 2 stretch) and cdiv toggles throughout.
REQ-034 halt=1 in EXEC -> HALTED after the advance edge, nstop_req=0, cdiv=0 held, retired incremented; start pulse -> FETCH on the next edge, nstop_req=1.
REQ-035 Preload the counter via 65535 instructions with CNT_W=16 -> the next WRITE->FETCH gives retired=0.
REQ-036 nreset pulsed low in OPERAND during mem_wait -> outputs reset immediately, without waiting for clk; retired unchanged from 0 after reset.
REQ-037 start=1 and halt=1 together in EXEC -> enters HALTED and stays there until start is seen in HALTED.
